full_adder: RTL and testbench

Single-bit (width-parameterisable) binary full adder. It produces the sum and carry-out of A + B + Cin combinationally, with an optional registered copy of the result for pipelined consumers. It is the basic arithmetic leaf cell for ripple-carry adders and ALU datapaths in the logic-circuits library.

---
 rtl/fa_pkg.sv | 4 +
 rtl/fa_cell.sv | 14 +
 rtl/full_adder.sv | 42 ++++
 tb/tb_full_adder.sv | 110 +++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants for the full-adder leaf cell and its ripple-carry wrapper.
package fa_pkg;
  localparam int FA_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; purely combinational, chained by full_adder into a ripple.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and a one-cycle registered copy.
module full_adder
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_r,
  output logic             Cout_r
);
  logic [WIDTH:0] c;

  assign c[0] = Cin;
  assign Cout = c[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (Sum[i]),
      .cout (c[i+1])
    );
  end

  // Reset only touches the registered copy; Sum/Cout stay live during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum_r  <= '0;
      Cout_r <= 1'b0;
    end else begin
      Sum_r  <= Sum;
      Cout_r <= Cout;
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// Directed + random checks of full_adder at WIDTH=1 and WIDTH=4 against arithmetic A+B+Cin.
module tb_full_adder;
  logic       clk, clk_en, rst_n;
  logic       a1, b1, cin1, s1, c1, sr1, cr1;
  logic [3:0] a4, b4, s4, sr4;
  logic       cin4, c4, cr4;
  int         checks, failures;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
    .Sum(s1), .Cout(c1), .Sum_r(sr1), .Cout_r(cr1)
  );

  full_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4),
    .Sum(s4), .Cout(c4), .Sum_r(sr4), .Cout_r(cr4)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] tab [8];
    logic [2:0] v;
    logic [4:0] exp4, prev4;
    logic [1:0] exp1, prev1;
    tab = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    checks = 0; failures = 0;
    clk_en = 1'b0; rst_n = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0; a4 = 0; b4 = 0; cin4 = 0;

    // Exhaustive 1-bit truth table with the clock held still
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {a1, b1, cin1} = v;
      #10;
      chk($sformatf("w1_tt_%0d", i), {6'd0, s1, c1}, {6'd0, tab[i]});
    end

    a1 = 1; b1 = 1; cin1 = 1; #3;
    chk("comb_in_reset_sum", {7'd0, s1}, 8'd1);
    chk("comb_in_reset_cout", {7'd0, c1}, 8'd1);

    clk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_w1", {6'd0, sr1, cr1}, 8'd0);
    chk("reset_w4", {3'd0, cr4, sr4}, 8'd0);

    // Registered latency
    rst_n = 1'b1; a1 = 0; b1 = 0; cin1 = 0;
    @(negedge clk);
    chk("lat_pre", {6'd0, sr1, cr1}, 8'd0);
    a1 = 1; b1 = 0; cin1 = 1; #1;
    chk("lat_hold", {6'd0, sr1, cr1}, 8'd0);
    @(negedge clk);
    chk("lat_sum_r", {7'd0, sr1}, 8'd0);
    chk("lat_cout_r", {7'd0, cr1}, 8'd1);

    a4 = 4'b1111; b4 = 4'b0001; cin4 = 0; #1;
    chk("ripple_full", {3'd0, c4, s4}, 8'b0001_0000);
    a4 = 4'b0101; b4 = 4'b0011; cin4 = 1; #1;
    chk("ripple_mix", {3'd0, c4, s4}, 8'b0000_1001);

    // Reset mid-stream
    a1 = 1; b1 = 1; cin1 = 1;
    @(negedge clk);
    chk("mid_pre", {6'd0, sr1, cr1}, 8'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_regs", {6'd0, sr1, cr1}, 8'b00);
    chk("mid_reset_comb", {6'd0, s1, c1}, 8'b11);
    a1 = 1; b1 = 0; cin1 = 0; #1;
    chk("mid_reset_track", {6'd0, s1, c1}, 8'b10);
    rst_n = 1'b1;
    chk("mid_still_zero", {6'd0, sr1, cr1}, 8'b00);
    @(negedge clk);
    chk("mid_resume", {6'd0, sr1, cr1}, 8'b10);

    // Random: combinational now, registered one edge later
    prev4 = '0; prev1 = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rnd_reg_w4", {3'd0, cr4, sr4}, {3'd0, prev4});
        chk("rnd_reg_w1", {6'd0, cr1, sr1}, {6'd0, prev1});
      end
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      exp4 = 5'(a4) + 5'(b4) + 5'(cin4);
      exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
      #1;
      chk("rnd_comb_w4", {3'd0, c4, s4}, {3'd0, exp4});
      chk("rnd_comb_w1", {6'd0, c1, s1}, {6'd0, exp1});
      prev4 = exp4; prev1 = exp1;
    end
    @(negedge clk);
    chk("rnd_reg_last", {3'd0, cr4, sr4}, {3'd0, prev4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
